// File: rtl/alu_logic_pkg.sv
// Shared opcode and FSM state encodings for the serial bitwise logic unit.
package alu_logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator over one SLICE_W-bit slice.
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [1:0]         op,
  output logic [SLICE_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_serial.sv
// Handshaked bitwise logic unit: evaluates one SLICE_W slice per cycle, LSB first,
// and presents the DATA_W result plus a registered zero flag on the response port.
module alu_logic_serial
  import alu_logic_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_zero,
  output logic              busy
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE_W < 1 || (DATA_W % SLICE_W) != 0) begin : g_param_chk
    $error("alu_logic_serial: DATA_W must be a positive multiple of SLICE_W");
  end

  state_e              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   a_q, b_q, y_q;
  logic [1:0]          op_q;
  logic                zero_q;

  logic [SLICE_W-1:0]  a_sl, b_sl, y_sl;
  logic [DATA_W-1:0]   y_upd;
  logic                last;

  always_comb begin
    a_sl  = a_q[int'(cnt)*SLICE_W +: SLICE_W];
    b_sl  = b_q[int'(cnt)*SLICE_W +: SLICE_W];
    y_upd = y_q;
    y_upd[int'(cnt)*SLICE_W +: SLICE_W] = y_sl;
    last  = (int'(cnt) == NSLICE - 1);
  end

  logic_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign rsp_y     = y_q;
  // zero flag only means something while a response is being offered
  assign rsp_zero  = zero_q && rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      y_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (req_valid) begin
          a_q    <= req_a;
          b_q    <= req_b;
          op_q   <= req_op;
          y_q    <= '0;
          cnt    <= '0;
          zero_q <= 1'b0;
        end
        ST_RUN: begin
          y_q <= y_upd;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) zero_q <= (y_upd == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logic_serial.sv
// Self-checking bench for alu_logic_serial: directed vector table, corner sequences,
// and randomized back-to-back traffic against a full-width reference model.
module tb_alu_logic_serial;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_zero;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_logic_serial #(.DATA_W(DATA_W), .SLICE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] y;
    logic              z;
  } vec_t;

  function automatic logic [DATA_W-1:0] ref_op(input logic [1:0] op,
                                               input logic [DATA_W-1:0] a, b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // all tasks start and end at posedge+1
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [DATA_W-1:0] a, b,
                       output logic [DATA_W-1:0] y, output logic z, output int lat);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    chk("accept_ready", {31'd0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    y = rsp_y;
    z = rsp_zero;
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("valid_drop", {31'd0, rsp_valid}, 0);
  endtask

  vec_t tbl[5];
  logic [DATA_W-1:0] y, e;
  logic              z;
  int                lat;
  logic [DATA_W-1:0] q[$];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    tbl[0] = '{2'd0, 32'hF0F0_A5A5, 32'hFF00_0F0F, 32'hF000_0505, 1'b0};
    tbl[1] = '{2'd2, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[2] = '{2'd1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[3] = '{2'd3, 32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
    tbl[4] = '{2'd0, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0000, 1'b1};

    // reset values
    #12;
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, y, z, lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_y", i), y, tbl[i].y);
      chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, tbl[i].z});
      rsp_handshake();
    end

    // backpressure: DONE held with stable outputs; request ignored meanwhile
    do_op(2'd3, 32'h0, 32'h0000_FFFF, y, z, lat);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'hDEAD_BEEF; req_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 1);
      chk("bp_y", rsp_y, 32'hFFFF_0000);
      chk("bp_zero", {31'd0, rsp_zero}, 0);
      chk("bp_req_ready", {31'd0, req_ready}, 0);
    end
    req_valid = 1'b0;
    rsp_handshake();

    // inputs changing during RUN; held request accepted only after IDLE
    req_op = 2'd0; req_a = 32'hFFFF_00FF; req_b = 32'h0F0F_F0F0; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("chg_busy", {31'd0, busy}, 1);
    chk("chg_req_ready", {31'd0, req_ready}, 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      req_op = 2'($urandom_range(0, 3)); req_a = $urandom; req_b = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    chk("chg_latency", lat, 4);
    chk("chg_y", rsp_y, 32'h0F0F_00F0);
    req_op = 2'd2; req_a = 32'hCAFE_1234; req_b = 32'h0F0F_0F0F;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("chg_idle_valid", {31'd0, rsp_valid}, 0);
    chk("chg_idle_ready", {31'd0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("chg_second_busy", {31'd0, busy}, 1);
    wait_rsp(lat);
    chk("chg_second_latency", lat, 4);
    chk("chg_second_y", rsp_y, ref_op(2'd2, 32'hCAFE_1234, 32'h0F0F_0F0F));
    rsp_handshake();

    // reset in the middle of RUN
    req_op = 2'd1; req_a = 32'hFFFF_FFFF; req_b = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_y", rsp_y, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_valid", {31'd0, rsp_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_req_ready", {31'd0, req_ready}, 1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) lat++;
    end
    chk("midrst_no_rsp", lat, 0);
    chk("midrst_y_after", rsp_y, 0);

    // randomized back-to-back traffic with rsp_ready tied high
    begin
      int  n_rsp, cyc, last_acc;
      logic acc, hs;
      n_rsp = 0; cyc = 0; last_acc = -1;
      rsp_ready = 1'b1; req_valid = 1'b1;
      req_op = 2'($urandom_range(0, 3)); req_a = $urandom; req_b = $urandom;
      while (n_rsp < 1000 && cyc < 7000) begin
        acc = req_ready;
        hs  = rsp_valid;
        if (hs) begin
          if (q.size() == 0) begin
            chk("b2b_unexpected_rsp", 1, 0);
          end else begin
            e = q.pop_front();
            chk("b2b_y", rsp_y, e);
            chk("b2b_zero", {31'd0, rsp_zero}, {31'd0, (e == '0)});
          end
          n_rsp++;
        end
        if (acc) begin
          q.push_back(ref_op(req_op, req_a, req_b));
          if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, 6);
          last_acc = cyc;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          req_op = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0:       begin req_a = $urandom; req_b = req_a; end
            1:       begin req_a = 32'h0; req_b = $urandom; end
            default: begin req_a = $urandom; req_b = $urandom; end
          endcase
        end
      end
      chk("b2b_count", n_rsp, 1000);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
